// File: rtl/caxi4interconnect_thread_tracker_pkg.sv
// -----------------------------------------------------------------------------
// caxi4interconnect_thread_tracker_pkg
// Shared definitions for the outstanding-transaction thread tracker:
//   - slot-index sizing (up to MAX_THREADS slots, THREAD_IDX_WIDTH-bit index)
//   - COUNT_ONE, the count a freshly allocated slot starts at
//   - onehot_to_bin(), used for both matched-slot and free-slot selection
// Optional feature macro used by the files importing this package:
//   CAXI4_THREAD_TRACK_ERR_CHECK_EN (sticky threadErr flag).
// -----------------------------------------------------------------------------
package caxi4interconnect_thread_tracker_pkg;

  localparam int MAX_THREADS      = 8;
  localparam int THREAD_IDX_WIDTH = 3;
  localparam int COUNT_ONE        = 1;

  // Encodes a slot-select vector to a binary index. The scan runs from the top
  // down so the lowest set bit is the one returned; this makes the function
  // safe on vectors with several bits set (illegal duplicate matches, or the
  // whole free-slot vector) and gives lowest-index priority for free.
  function automatic logic [THREAD_IDX_WIDTH-1:0] onehot_to_bin(
    input logic [MAX_THREADS-1:0] vec
  );
    logic [THREAD_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = MAX_THREADS - 1; i >= 0; i--) begin
      if (vec[i]) idx = THREAD_IDX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/caxi4interconnect_thread_slot.sv
// -----------------------------------------------------------------------------
// caxi4interconnect_thread_slot
// One tracker slot: valid flag, master ID, target slave ID and open count.
// Applies allocate / increment / decrement for this slot, saturating the count
// at 0 and OPEN_TRANS_MAX.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inc_hit           increment aimed at this (already valid) slot
//   dec_hit           decrement aimed at this (already valid) slot
//   alloc             allocate this (currently free) slot
//   alloc_id          master ID stored on allocation
//   alloc_slave_id    slave ID stored on allocation
//   valid, id, slave_id, count   registered slot state
//   err               (CAXI4_THREAD_TRACK_ERR_CHECK_EN only) one-cycle pulse on
//                     an overflowing increment or underflowing decrement
// -----------------------------------------------------------------------------
module caxi4interconnect_thread_slot
  import caxi4interconnect_thread_tracker_pkg::*;
#(
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inc_hit,
  input  logic                        dec_hit,
  input  logic                        alloc,
  input  logic [MASTERID_WIDTH-1:0]   alloc_id,
  input  logic [NUM_SLAVES_WIDTH-1:0] alloc_slave_id,
  output logic                        valid,
  output logic [MASTERID_WIDTH-1:0]   id,
  output logic [NUM_SLAVES_WIDTH-1:0] slave_id,
  output logic [OPEN_TRANS_WIDTH-1:0] count
`ifdef CAXI4_THREAD_TRACK_ERR_CHECK_EN
  ,
  output logic                        err
`endif
);

  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_ONE = OPEN_TRANS_WIDTH'(COUNT_ONE);
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_MAX = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);

  logic                        valid_d;
  logic [MASTERID_WIDTH-1:0]   id_d;
  logic [NUM_SLAVES_WIDTH-1:0] slave_id_d;
  logic [OPEN_TRANS_WIDTH-1:0] count_d;

  logic at_max;
  logic at_zero;

  assign at_max  = (count == CNT_MAX);
  assign at_zero = (count == '0);

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    valid_d    = valid;
    id_d       = id;
    slave_id_d = slave_id;
    count_d    = count;
    if (alloc) begin
      valid_d    = 1'b1;
      id_d       = alloc_id;
      slave_id_d = alloc_slave_id;
      count_d    = CNT_ONE;
    end else if (inc_hit && dec_hit) begin
      // Net zero: the slot stays open even at count 1.
      count_d = count;
    end else if (inc_hit) begin
      if (!at_max) count_d = count + CNT_ONE;
    end else if (dec_hit) begin
      if (!at_zero) begin
        count_d = count - CNT_ONE;
        if (count == CNT_ONE) valid_d = 1'b0;
      end
    end
  end

`ifdef CAXI4_THREAD_TRACK_ERR_CHECK_EN
  assign err = (inc_hit && !dec_hit && at_max) || (dec_hit && !inc_hit && at_zero);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering; the asynchronous reset
  // sits in the sensitivity list so slots clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      id       <= '0;
      slave_id <= '0;
      count    <= '0;
    end else begin
      valid    <= valid_d;
      id       <= id_d;
      slave_id <= slave_id_d;
      count    <= count_d;
    end
  end

endmodule

// File: rtl/caxi4interconnect_thread_tracker.sv
// -----------------------------------------------------------------------------
// caxi4interconnect_thread_tracker
// Per-master outstanding-transaction tracker for one direction. Holds
// NUM_THREADS slots (master ID, target slave, open count), reports the status
// of currTransID combinationally, increments on accepted address handshakes
// and decrements on final response handshakes.
// Ports:
//   sysClk, sysReset      clock, asynchronous active-low reset
//   currTransID           ID being looked up / incremented
//   currTransSlaveID      decoded target of the current request
//   openTransInc          address handshake accepted for currTransID
//   openTransDec          final response handshake for respID
//   respID                ID of the completing response
//   threadAvail           at least one free slot
//   threadValid           a valid slot matches currTransID
//   threadCount           matched slot count, 0 if none
//   threadSlaveID         matched slot slave ID, 0 if none
//   transIdle             all slots free
//   threadErr             sticky protocol-error flag; only implemented when
//                         CAXI4_THREAD_TRACK_ERR_CHECK_EN is defined, else 0
// -----------------------------------------------------------------------------
module caxi4interconnect_thread_tracker
  import caxi4interconnect_thread_tracker_pkg::*;
#(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_THREADS      = 1,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [MASTERID_WIDTH-1:0]   currTransID,
  input  logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
  input  logic                        openTransInc,
  input  logic                        openTransDec,
  input  logic [MASTERID_WIDTH-1:0]   respID,
  output logic                        threadAvail,
  output logic                        threadValid,
  output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
  output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
  output logic                        transIdle,
  output logic                        threadErr
);

  if (NUM_THREADS < 1 || NUM_THREADS > MAX_THREADS) begin : g_bad_threads
    $error("NUM_THREADS must be in 1..8");
  end
  if (NUM_SLAVES > (1 << NUM_SLAVES_WIDTH)) begin : g_bad_slaves
    $error("NUM_SLAVES_WIDTH too narrow for NUM_SLAVES");
  end
  if (OPEN_TRANS_MAX >= (1 << OPEN_TRANS_WIDTH)) begin : g_bad_count
    $error("OPEN_TRANS_WIDTH too narrow for OPEN_TRANS_MAX");
  end

  logic                        slot_valid    [NUM_THREADS];
  logic [MASTERID_WIDTH-1:0]   slot_id       [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0] slot_slave_id [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0] slot_count    [NUM_THREADS];

  logic [NUM_THREADS-1:0] match_vec, resp_vec, free_vec;
  logic [NUM_THREADS-1:0] inc_hit, dec_hit, alloc;

  logic [THREAD_IDX_WIDTH-1:0] match_idx, resp_idx, free_idx;
  logic match_any, resp_any, free_any;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      match_vec[i] = slot_valid[i] && (slot_id[i] == currTransID);
      resp_vec[i]  = slot_valid[i] && (slot_id[i] == respID);
      free_vec[i]  = !slot_valid[i];
    end
  end

  assign match_any = |match_vec;
  assign resp_any  = |resp_vec;
  assign free_any  = |free_vec;

  assign match_idx = onehot_to_bin(MAX_THREADS'(match_vec));
  assign resp_idx  = onehot_to_bin(MAX_THREADS'(resp_vec));
  assign free_idx  = onehot_to_bin(MAX_THREADS'(free_vec));

  // free_vec is pre-edge state, so a slot released by this cycle's decrement
  // is never a candidate for this cycle's allocation.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      inc_hit[i] = openTransInc && match_any && (match_idx == THREAD_IDX_WIDTH'(i));
      dec_hit[i] = openTransDec && resp_any && (resp_idx == THREAD_IDX_WIDTH'(i));
      alloc[i]   = openTransInc && !match_any && free_any &&
                   (free_idx == THREAD_IDX_WIDTH'(i));
    end
  end

`ifdef CAXI4_THREAD_TRACK_ERR_CHECK_EN
  logic [NUM_THREADS-1:0] slot_err;
`endif

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
    caxi4interconnect_thread_slot #(
      .MASTERID_WIDTH  (MASTERID_WIDTH),
      .NUM_SLAVES_WIDTH(NUM_SLAVES_WIDTH),
      .OPEN_TRANS_MAX  (OPEN_TRANS_MAX),
      .OPEN_TRANS_WIDTH(OPEN_TRANS_WIDTH)
    ) u_slot (
      .clk           (sysClk),
      .rst_n         (sysReset),
      .inc_hit       (inc_hit[g]),
      .dec_hit       (dec_hit[g]),
      .alloc         (alloc[g]),
      .alloc_id      (currTransID),
      .alloc_slave_id(currTransSlaveID),
      .valid         (slot_valid[g]),
      .id            (slot_id[g]),
      .slave_id      (slot_slave_id[g]),
      .count         (slot_count[g])
`ifdef CAXI4_THREAD_TRACK_ERR_CHECK_EN
      ,
      .err           (slot_err[g])
`endif
    );
  end

  always_comb begin
    threadCount   = '0;
    threadSlaveID = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (match_any && (match_idx == THREAD_IDX_WIDTH'(i))) begin
        threadCount   = slot_count[i];
        threadSlaveID = slot_slave_id[i];
      end
    end
  end

  assign threadAvail = free_any;
  assign threadValid = match_any;
  assign transIdle   = &free_vec;

`ifdef CAXI4_THREAD_TRACK_ERR_CHECK_EN
  logic inc_drop, dec_drop, err_event, err_q;

  assign inc_drop  = openTransInc && !match_any && !free_any;
  assign dec_drop  = openTransDec && !resp_any;
  assign err_event = inc_drop || dec_drop || (|slot_err);

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset)      err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign threadErr = err_q;

`ifndef SYNTHESIS
  always @(posedge sysClk) begin
    if (sysReset && err_event)
      $display("%m: illegal tracker event (inc_drop=%0b dec_drop=%0b slot_err=%b)",
               inc_drop, dec_drop, slot_err);
  end
`endif
`else
  assign threadErr = 1'b0;
`endif

endmodule

// File: doc/caxi4interconnect_thread_tracker.md
Name: caxi4interconnect_thread_tracker

Overview:
Per-master outstanding-transaction tracker for one direction (read or write), sitting directly upstream of the dependence checker in the crossbar address path. Holds NUM_THREADS slots, each recording an in-flight master ID, its target slave ID and its open-transaction count. Combinationally reports thread status for the current request ID. Increments on accepted address handshakes and decrements on completed responses.

Parameters:
NUM_SLAVES, 4, slave count including the DERR slave
NUM_SLAVES_WIDTH, 2, slave ID width
MASTERID_WIDTH, 4, infrastructure plus requestor ID width
NUM_THREADS, 1, number of independent ID slots (1..8)
OPEN_TRANS_MAX, 3, maximum open transactions per slot
OPEN_TRANS_WIDTH, 2, count width, sized to hold OPEN_TRANS_MAX

Ports:
sysClk  in  1  clock, rising edge
sysReset  in  1  asynchronous active-low reset
currTransID  in  MASTERID_WIDTH  ID of the request being qualified
currTransSlaveID  in  NUM_SLAVES_WIDTH  decoded target of the current request
openTransInc  in  1  address handshake accepted for currTransID/currTransSlaveID
openTransDec  in  1  final response handshake (BVALID&BREADY or RLAST&RVALID&RREADY)
respID  in  MASTERID_WIDTH  ID of the completing response
threadAvail  out  1  at least one free slot
threadValid  out  1  a valid slot matches currTransID
threadCount  out  OPEN_TRANS_WIDTH  count of the matched slot, 0 if none
threadSlaveID  out  NUM_SLAVES_WIDTH  slave of the matched slot, 0 if none
transIdle  out  1  all slots free
threadErr  out  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Slot state is registered: valid, id, slaveID and count. On reset, all slots are cleared. After reset, threadAvail=1, threadValid=0, threadCount=0, threadSlaveID=0, transIdle=1, threadErr=0.
- All outputs are combinational from registered state plus currTransID. There is zero-cycle lookup latency, and updates are visible the cycle after the event.
- Lookup: a match is slot.valid & (slot.id==currTransID). At most one slot matches. If multiple slots match (illegal), the lowest index wins.
- Inc when currTransID matches a slot: count+1. The stored slaveID is not rewritten, because the dependence checker already guaranteed the same target.
- Inc when currTransID matches no slot: allocate the lowest-index free slot with id=currTransID, slaveID=currTransSlaveID, count=1.
- Dec: the slot whose id==respID gets count-1. When the count reaches 0, valid is cleared.
- Inc and Dec on the same slot in the same cycle: count is unchanged and the slot stays valid, including when count=1.
- Inc and Dec on different slots in the same cycle: both apply independently.
- A slot freed by Dec in cycle N cannot be allocated by an Inc in cycle N. Allocation uses only pre-edge free slots.
- Inc with no free slot and no match, or Inc with count==OPEN_TRANS_MAX and no concurrent same-slot Dec: update is ignored and an error is raised. This is illegal upstream because validQual masks these cases.
- Dec with no matching respID, or Dec on count==0: ignored and an error is raised.
- Counts never wrap; they saturate at 0 and OPEN_TRANS_MAX.
- Reset asserted mid-operation clears all slots immediately, asynchronously. Deassertion is synchronised externally.

Optional Feature:
Macro CAXI4_THREAD_TRACK_ERR_CHECK_EN.
- Defined: threadErr is a sticky register set by any illegal event above and cleared only by reset. A simulation-only $display reports the event.
- Undefined: threadErr is tied to 0, error logic is not synthesised, and illegal events are silently ignored exactly as described.

Decomposition:
- Shared package/include holds:
  - slot field widths;
  - the one-hot-to-binary encode function used for matched and free slot selection;
  - localparam COUNT_ONE.
- One natural sub-module, caxi4interconnect_thread_slot, instantiated per thread. It contains the slot registers, inc/dec/alloc update, saturation and local error detect.
- The top level does match/priority selection, lowest-free allocation and output muxing.

Test Plan:
- Reset, then idle: threadAvail=1, threadValid=0, transIdle=1, threadCount=0.
- Single ID: NUM_THREADS=2, currTransID=4'h5 slave 2, three Incs → threadValid=1, threadSlaveID=2, threadCount=3. A fourth Inc is ignored and sets threadErr. Three Decs with respID=5 → slot freed, transIdle=1.
- Two IDs: Inc ID 1 (slave 0) then ID 2 (slave 1) with NUM_THREADS=2 → threadAvail=0. A lookup of ID 3 gives threadValid=0. Dec ID 1 → threadAvail=1 next cycle.
- Simultaneous: count=1 on ID 7, Inc and Dec both on ID 7 in the same cycle → count stays 1 and valid stays 1. A full table with Dec freeing a slot plus Inc of a new ID in the same cycle → Inc is ignored and flagged.
- Error: Dec respID=9 with no slot → threadErr=1 with the macro defined and 0 with it undefined; state is unchanged in both.
- Async reset asserted with 2 slots at count 2 → all outputs return to reset values without a clock edge.
